qpll_lock_monitor: RTL and testbench

- Receiving end of the QPLL common reset: watches the COMMON_RESET pulse from the reset generator, then tracks QPLLLOCK until lock is stable.
- Holds GT TX/RX resets until lock has been continuously stable, then releases them and asserts PLL_READY.
- On lock timeout or loss of lock, requests a fresh QPLL reset with a single-cycle pulse, up to a retry limit; beyond the limit it declares failure.
- Sits between the common reset generator and the per-channel GT reset logic.

---
 rtl/qpll_lock_monitor.sv | 220 ++++++++++++++++++++++
 tb/tb_qpll_lock_monitor.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/qpll_lock_monitor.sv
// rtl/qpll_lock_monitor.sv - QPLL lock monitor: holds GT resets until QPLL lock is stable, retries on failure
//
// Purpose:
//   Receiving end of the QPLL common reset. After a COMMON_RESET pulse it
//   tracks the synchronized QPLLLOCK. Once lock has been stable for
//   LOCK_STABLE_CYCLES it releases the GT TX/RX resets and raises PLL_READY.
//   On lock timeout or loss of lock it requests a fresh QPLL reset with a
//   one-cycle pulse, up to MAX_RETRIES times, and then declares a sticky
//   failure.
//
// Ports:
//   i_stable_clock     single clock for all logic
//   i_soft_reset       synchronous active-high reset
//   i_common_reset     QPLL reset pulse from the common reset generator
//   i_qplllock         QPLL lock (asynchronous)
//   i_qpllrefclklost   QPLL reference clock lost (asynchronous)
//   o_qpll_reset_req   one-cycle retry request, ORed externally into QPLLRESET
//   o_gt_tx_reset      GT TX reset, active-high
//   o_gt_rx_reset      GT RX reset, active-high
//   o_pll_ready        lock stable, GT resets released
//   o_lock_fail        sticky failure flag
//   o_retry_count      retries issued since last sequence start
//
// Optional feature macro: QPLL_REFCLKLOST_CHECK_EN
//   Defined: a synchronized refclk-lost forces lock to be treated as absent.
//   Undefined: i_qpllrefclklost is ignored and has no synchronizer.

module qpll_lock_monitor #(
  parameter int STABLE_CLOCK_PERIOD = 8,
  parameter int LOCK_TIMEOUT_NS     = 16000,
  parameter int LOCK_STABLE_CYCLES  = 64,
  parameter int MAX_RETRIES         = 4
) (
  input  logic       i_stable_clock,
  input  logic       i_soft_reset,
  input  logic       i_common_reset,
  input  logic       i_qplllock,
  input  logic       i_qpllrefclklost,
  output logic       o_qpll_reset_req,
  output logic       o_gt_tx_reset,
  output logic       o_gt_rx_reset,
  output logic       o_pll_ready,
  output logic       o_lock_fail,
  output logic [3:0] o_retry_count
);

  localparam int          TIMEOUT_CYCLES = LOCK_TIMEOUT_NS / STABLE_CLOCK_PERIOD;
  localparam logic [23:0] TO_LAST        = 24'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0]  ST_LAST        = 8'(LOCK_STABLE_CYCLES - 1);
  localparam logic [3:0]  RETRY_MAX      = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_IDLE        = 3'd0,
    S_WAIT_LOCK   = 3'd1,
    S_LOCK_STABLE = 3'd2,
    S_READY       = 3'd3,
    S_RETRY       = 3'd4,
    S_FAIL        = 3'd5
  } state_t;

  state_t      r_state;
  state_t      w_state_nxt;
  logic [23:0] r_to_cnt;
  logic [7:0]  r_st_cnt;
  logic        r_lock_meta;
  logic        r_lock_s;
  logic        r_req;
  logic        r_gt_reset;
  logic        r_ready;
  logic        r_fail;
  logic [3:0]  r_retry;

  logic        w_lock;
  logic        w_timeout;
  logic        w_stable_done;
  logic        w_retry_ok;
  logic        w_restart;
  logic        w_to_clr;
  logic        w_to_inc;
  logic        w_st_clr;
  logic        w_st_inc;

`ifdef QPLL_REFCLKLOST_CHECK_EN
  logic r_lost_meta;
  logic r_lost_s;

  always_ff @(posedge i_stable_clock) begin
    if (i_soft_reset) begin
      r_lost_meta <= 1'b0;
      r_lost_s    <= 1'b0;
    end else begin
      r_lost_meta <= i_qpllrefclklost;
      r_lost_s    <= r_lost_meta;
    end
  end

  assign w_lock = r_lock_s & ~r_lost_s;
`else
  logic w_unused_lost;
  assign w_unused_lost = i_qpllrefclklost;
  assign w_lock        = r_lock_s;
`endif

  // >= rather than == so a timeout that lands while WAIT_LOCK is taking
  // the lock branch still fires on the following LOCK_STABLE cycle.
  assign w_timeout  = (r_to_cnt >= TO_LAST);
  assign w_retry_ok = (r_retry < RETRY_MAX);
  // The WAIT_LOCK cycle that first saw lock is the first stable sample, so
  // N consecutive samples are complete when the post-increment count hits N-1.
  assign w_stable_done = ((r_st_cnt + 8'd1) == ST_LAST);

  always_comb begin
    w_state_nxt = r_state;
    w_restart   = 1'b0;
    w_to_clr    = 1'b0;
    w_to_inc    = 1'b0;
    w_st_clr    = 1'b0;
    w_st_inc    = 1'b0;
    if (i_common_reset && (r_state != S_IDLE)) begin
      w_restart   = 1'b1;
      w_to_clr    = 1'b1;
      w_state_nxt = S_WAIT_LOCK;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (i_common_reset) begin
            w_to_clr    = 1'b1;
            w_state_nxt = S_WAIT_LOCK;
          end
        end
        S_WAIT_LOCK: begin
          w_to_inc = 1'b1;
          if (w_lock) begin
            w_st_clr    = 1'b1;
            w_state_nxt = (LOCK_STABLE_CYCLES == 1) ? S_READY : S_LOCK_STABLE;
          end else if (w_timeout) begin
            w_state_nxt = w_retry_ok ? S_RETRY : S_FAIL;
          end
        end
        S_LOCK_STABLE: begin
          // Timeout keeps running here so a chattering lock cannot extend it;
          // stable-count completion beats a coincident timeout.
          w_to_inc = 1'b1;
          if (w_lock && w_stable_done) begin
            w_state_nxt = S_READY;
          end else if (w_timeout) begin
            w_state_nxt = w_retry_ok ? S_RETRY : S_FAIL;
          end else if (w_lock) begin
            w_st_inc = 1'b1;
          end else begin
            w_state_nxt = S_WAIT_LOCK;
          end
        end
        S_READY: begin
          if (!w_lock) begin
            w_state_nxt = w_retry_ok ? S_RETRY : S_FAIL;
          end
        end
        S_RETRY: begin
          w_to_clr    = 1'b1;
          w_state_nxt = S_WAIT_LOCK;
        end
        S_FAIL: begin
          w_state_nxt = S_FAIL;
        end
        default: begin
          w_state_nxt = S_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge i_stable_clock) begin
    if (i_soft_reset) begin
      r_state     <= S_IDLE;
      r_to_cnt    <= '0;
      r_st_cnt    <= '0;
      r_lock_meta <= 1'b0;
      r_lock_s    <= 1'b0;
      r_req       <= 1'b0;
      r_gt_reset  <= 1'b1;
      r_ready     <= 1'b0;
      r_fail      <= 1'b0;
      r_retry     <= '0;
    end else begin
      r_lock_meta <= i_qplllock;
      r_lock_s    <= r_lock_meta;
      r_state     <= w_state_nxt;
      if (w_to_clr) begin
        r_to_cnt <= '0;
      end else if (w_to_inc) begin
        r_to_cnt <= r_to_cnt + 24'd1;
      end
      if (w_st_clr) begin
        r_st_cnt <= '0;
      end else if (w_st_inc) begin
        r_st_cnt <= r_st_cnt + 8'd1;
      end
      // Outputs are decoded from the next state so they change on the same
      // edge the state does.
      r_req      <= (w_state_nxt == S_RETRY);
      r_gt_reset <= (w_state_nxt != S_READY);
      r_ready    <= (w_state_nxt == S_READY);
      r_fail     <= (w_state_nxt == S_FAIL);
      if (w_restart) begin
        r_retry <= '0;
      end else if ((w_state_nxt == S_RETRY) && (r_retry != 4'hF)) begin
        r_retry <= r_retry + 4'd1;
      end
    end
  end

  assign o_qpll_reset_req = r_req;
  assign o_gt_tx_reset    = r_gt_reset;
  assign o_gt_rx_reset    = r_gt_reset;
  assign o_pll_ready      = r_ready;
  assign o_lock_fail      = r_fail;
  assign o_retry_count    = r_retry;

endmodule

// File: tb/tb_qpll_lock_monitor.sv
// tb/tb_qpll_lock_monitor.sv - directed self-checking bench for qpll_lock_monitor

module tb_qpll_lock_monitor;

  logic       clk = 1'b0;
  logic       soft_reset;
  logic       common_reset;
  logic       qplllock;
  logic       qpllrefclklost;
  logic       qpll_reset_req;
  logic       gt_tx_reset;
  logic       gt_rx_reset;
  logic       pll_ready;
  logic       lock_fail;
  logic [3:0] retry_count;

  int n_cmp = 0;
  int n_err = 0;

  always #4 clk = ~clk;

  qpll_lock_monitor #(
    .STABLE_CLOCK_PERIOD(8),
    .LOCK_TIMEOUT_NS    (800),
    .LOCK_STABLE_CYCLES (16),
    .MAX_RETRIES        (2)
  ) dut (
    .i_stable_clock  (clk),
    .i_soft_reset    (soft_reset),
    .i_common_reset  (common_reset),
    .i_qplllock      (qplllock),
    .i_qpllrefclklost(qpllrefclklost),
    .o_qpll_reset_req(qpll_reset_req),
    .o_gt_tx_reset   (gt_tx_reset),
    .o_gt_rx_reset   (gt_rx_reset),
    .o_pll_ready     (pll_ready),
    .o_lock_fail     (lock_fail),
    .o_retry_count   (retry_count)
  );

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic pulse_common();
    common_reset = 1'b1;
    step();
    common_reset = 1'b0;
  endtask

  task automatic do_soft_reset();
    soft_reset = 1'b1;
    step();
    soft_reset = 1'b0;
    step();
  endtask

  task automatic test_reset();
    int req_seen;
    soft_reset = 1'b1;
    step();
    step();
    n_cmp++; if (gt_tx_reset !== 1'b1) begin n_err++; $display("FAIL reset_gt_tx: got %b want 1", gt_tx_reset); end
    n_cmp++; if (gt_rx_reset !== 1'b1) begin n_err++; $display("FAIL reset_gt_rx: got %b want 1", gt_rx_reset); end
    n_cmp++; if (pll_ready !== 1'b0) begin n_err++; $display("FAIL reset_ready: got %b want 0", pll_ready); end
    n_cmp++; if (qpll_reset_req !== 1'b0) begin n_err++; $display("FAIL reset_req: got %b want 0", qpll_reset_req); end
    n_cmp++; if (lock_fail !== 1'b0) begin n_err++; $display("FAIL reset_fail: got %b want 0", lock_fail); end
    n_cmp++; if (retry_count !== 4'd0) begin n_err++; $display("FAIL reset_retry: got %0d want 0", retry_count); end
    soft_reset = 1'b0;
    req_seen = 0;
    for (int i = 0; i < 150; i++) begin
      step();
      if (qpll_reset_req === 1'b1) req_seen++;
    end
    n_cmp++; if (req_seen != 0) begin n_err++; $display("FAIL idle_no_req: got %0d pulses want 0", req_seen); end
  endtask

  task automatic test_nominal();
    int first_ready;
    int req_seen;
    first_ready = -1;
    req_seen = 0;
    qplllock = 1'b0;
    pulse_common();
    for (int n = 1; n <= 30; n++) begin
      step();
      if (qpll_reset_req === 1'b1) req_seen++;
    end
    qplllock = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (qpll_reset_req === 1'b1) req_seen++;
      if (first_ready < 0 && pll_ready === 1'b1) first_ready = k;
    end
    n_cmp++; if (first_ready != 18) begin n_err++; $display("FAIL nominal_ready_cycle: got %0d want 18", first_ready); end
    n_cmp++; if (gt_tx_reset !== 1'b0 || gt_rx_reset !== 1'b0) begin n_err++; $display("FAIL nominal_gt_release: got tx=%b rx=%b want 0 0", gt_tx_reset, gt_rx_reset); end
    n_cmp++; if (req_seen != 0) begin n_err++; $display("FAIL nominal_no_req: got %0d pulses want 0", req_seen); end
    n_cmp++; if (retry_count !== 4'd0) begin n_err++; $display("FAIL nominal_retry: got %0d want 0", retry_count); end
  endtask

  task automatic test_loss_in_ready();
    int first_drop;
    int req_seen;
    int first_ready;
    first_drop = -1;
    req_seen = 0;
    first_ready = -1;
    qplllock = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      step();
      if (qpll_reset_req === 1'b1) req_seen++;
      if (first_drop < 0 && pll_ready === 1'b0) begin
        first_drop = k;
        n_cmp++; if (gt_tx_reset !== 1'b1 || gt_rx_reset !== 1'b1) begin n_err++; $display("FAIL loss_gt_reassert: got tx=%b rx=%b want 1 1", gt_tx_reset, gt_rx_reset); end
      end
    end
    n_cmp++; if (first_drop != 3) begin n_err++; $display("FAIL loss_drop_cycle: got %0d want 3", first_drop); end
    n_cmp++; if (req_seen != 1) begin n_err++; $display("FAIL loss_req_pulses: got %0d want 1", req_seen); end
    qplllock = 1'b1;
    for (int k = 1; k <= 40; k++) begin
      step();
      if (first_ready < 0 && pll_ready === 1'b1) first_ready = k;
    end
    n_cmp++; if (first_ready != 18) begin n_err++; $display("FAIL loss_relock_cycle: got %0d want 18", first_ready); end
    n_cmp++; if (retry_count !== 4'd1) begin n_err++; $display("FAIL loss_retry: got %0d want 1", retry_count); end
  endtask

  task automatic test_refclklost();
    int first_drop;
    int req_seen;
    first_drop = -1;
    req_seen = 0;
    qpllrefclklost = 1'b1;
    for (int k = 1; k <= 6; k++) begin
      step();
      if (qpll_reset_req === 1'b1) req_seen++;
      if (first_drop < 0 && pll_ready === 1'b0) first_drop = k;
    end
    qpllrefclklost = 1'b0;
`ifdef QPLL_REFCLKLOST_CHECK_EN
    n_cmp++; if (first_drop != 3) begin n_err++; $display("FAIL lost_drop_cycle: got %0d want 3", first_drop); end
    n_cmp++; if (req_seen != 1) begin n_err++; $display("FAIL lost_req_pulses: got %0d want 1", req_seen); end
`else
    n_cmp++; if (first_drop != -1) begin n_err++; $display("FAIL lost_ignored: ready dropped at %0d want never", first_drop); end
    n_cmp++; if (req_seen != 0) begin n_err++; $display("FAIL lost_no_req: got %0d pulses want 0", req_seen); end
`endif
  endtask

  task automatic test_timeout_retries();
    int req_pos[2];
    int req_seen;
    int first_fail;
    int bad_hold;
    req_pos[0] = -1;
    req_pos[1] = -1;
    req_seen = 0;
    first_fail = -1;
    bad_hold = 0;
    qplllock = 1'b0;
    qpllrefclklost = 1'b0;
    do_soft_reset();
    pulse_common();
    for (int n = 1; n <= 310; n++) begin
      step();
      if (qpll_reset_req === 1'b1) begin
        if (req_seen < 2) req_pos[req_seen] = n;
        req_seen++;
      end
      if (n == 100) begin
        n_cmp++; if (retry_count !== 4'd1) begin n_err++; $display("FAIL to_retry1: got %0d want 1", retry_count); end
      end
      if (n == 201) begin
        n_cmp++; if (retry_count !== 4'd2) begin n_err++; $display("FAIL to_retry2: got %0d want 2", retry_count); end
      end
      if (first_fail < 0 && lock_fail === 1'b1) first_fail = n;
    end
    n_cmp++; if (req_pos[0] != 100) begin n_err++; $display("FAIL to_req1_cycle: got %0d want 100", req_pos[0]); end
    n_cmp++; if (req_pos[1] != 201) begin n_err++; $display("FAIL to_req2_cycle: got %0d want 201", req_pos[1]); end
    n_cmp++; if (req_seen != 2) begin n_err++; $display("FAIL to_req_pulses: got %0d want 2", req_seen); end
    n_cmp++; if (first_fail != 302) begin n_err++; $display("FAIL to_fail_cycle: got %0d want 302", first_fail); end
    for (int n = 0; n < 500; n++) begin
      step();
      if (lock_fail !== 1'b1 || pll_ready !== 1'b0 || gt_tx_reset !== 1'b1 || qpll_reset_req !== 1'b0) bad_hold++;
    end
    n_cmp++; if (bad_hold != 0) begin n_err++; $display("FAIL fail_sticky: got %0d bad cycles want 0", bad_hold); end
    n_cmp++; if (retry_count !== 4'd2) begin n_err++; $display("FAIL fail_retry: got %0d want 2", retry_count); end
  endtask

  task automatic test_restart();
    int first_req;
    int req_seen;
    first_req = -1;
    req_seen = 0;
    qplllock = 1'b0;
    pulse_common();
    n_cmp++; if (lock_fail !== 1'b0) begin n_err++; $display("FAIL restart_fail_clr: got %b want 0", lock_fail); end
    n_cmp++; if (retry_count !== 4'd0) begin n_err++; $display("FAIL restart_retry_clr: got %0d want 0", retry_count); end
    n_cmp++; if (gt_tx_reset !== 1'b1 || pll_ready !== 1'b0) begin n_err++; $display("FAIL restart_outputs: got tx=%b ready=%b want 1 0", gt_tx_reset, pll_ready); end
    for (int n = 1; n <= 100; n++) begin
      step();
      if (first_req < 0 && qpll_reset_req === 1'b1) first_req = n;
    end
    n_cmp++; if (first_req != 100) begin n_err++; $display("FAIL restart_req_cycle: got %0d want 100", first_req); end
    soft_reset = 1'b1;
    common_reset = 1'b1;
    step();
    soft_reset = 1'b0;
    common_reset = 1'b0;
    n_cmp++; if ({gt_tx_reset, gt_rx_reset, pll_ready, qpll_reset_req, lock_fail, retry_count} !== 9'b110000000) begin
      n_err++;
      $display("FAIL soft_over_common: got tx=%b rx=%b rdy=%b req=%b fail=%b cnt=%0d want 1 1 0 0 0 0",
               gt_tx_reset, gt_rx_reset, pll_ready, qpll_reset_req, lock_fail, retry_count);
    end
    for (int n = 0; n < 150; n++) begin
      step();
      if (qpll_reset_req === 1'b1) req_seen++;
    end
    n_cmp++; if (req_seen != 0) begin n_err++; $display("FAIL soft_stays_idle: got %0d pulses want 0", req_seen); end
  endtask

  task automatic test_chatter();
    int ready_seen;
    int first_req;
    ready_seen = 0;
    first_req = -1;
    qplllock = 1'b0;
    do_soft_reset();
    pulse_common();
    for (int n = 1; n <= 110; n++) begin
      qplllock = (((n - 1) / 10) % 2) == 1;
      step();
      if (pll_ready === 1'b1) ready_seen++;
      if (first_req < 0 && qpll_reset_req === 1'b1) first_req = n;
    end
    n_cmp++; if (ready_seen != 0) begin n_err++; $display("FAIL chatter_never_ready: got %0d ready cycles want 0", ready_seen); end
    n_cmp++; if (first_req != 100) begin n_err++; $display("FAIL chatter_timeout_cycle: got %0d want 100", first_req); end
    n_cmp++; if (retry_count !== 4'd1) begin n_err++; $display("FAIL chatter_retry: got %0d want 1", retry_count); end
  endtask

  initial begin
    soft_reset     = 1'b1;
    common_reset   = 1'b0;
    qplllock       = 1'b0;
    qpllrefclklost = 1'b0;
    @(negedge clk);
    test_reset();
    test_nominal();
    test_loss_in_ready();
    test_refclklost();
    test_timeout_retries();
    test_restart();
    test_chatter();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
